riscv_dcache_ctrl: RTL and testbench

- Parametrised direct-mapped, write-through, read-allocate data-cache controller between the RISC-V core's data-memory port and main memory.
- Returns read hits combinationally, stalls the core on misses and writes, and refills lines word by word over a ready-handshaked memory port.
- Adds flush and saturating hit/miss counters, so the system testbench can measure cache behaviour.

---
 rtl/riscv_cache_pkg.sv | 30 +++
 rtl/cache_sat_counter.sv | 30 +++
 rtl/riscv_dcache_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_riscv_dcache_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_cache_pkg.sv
// riscv_cache_pkg
//   Shared types and address-split helpers for the direct-mapped data cache.
//   - state_e      : controller states (idle, line refill, write-through)
//   - BYTE_OFF_W   : byte-offset width of a 32-bit word address
//   - word_off_w() : word-within-line field width
//   - index_w()    : line-index field width
//   - tag_w()      : tag field width (everything above index)
package riscv_cache_pkg;

  localparam int BYTE_OFF_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_WRITE  = 2'd2
  } state_e;

  function automatic int word_off_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int index_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int lines, input int words_per_line);
    return addr_w - BYTE_OFF_W - word_off_w(words_per_line) - index_w(lines);
  endfunction

endpackage

// File: rtl/cache_sat_counter.sv
// cache_sat_counter
//   Saturating up-counter used for cache performance statistics.
//   Ports:
//     clk     - clock
//     rst_n   - asynchronous active-low reset, clears the count
//     inc_i   - increment request for this cycle
//     count_o - current count; holds at all-ones instead of wrapping
module cache_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/riscv_dcache_ctrl.sv
// riscv_dcache_ctrl
//   Direct-mapped, write-through, read-allocate data-cache controller.
//   Ports:
//     CLK, RST              - clock, asynchronous active-low reset
//     cpu_rd / cpu_wr       - load / store request (store wins if both set)
//     cpu_addr, cpu_wdata   - word-aligned byte address, store data
//     cpu_flush             - invalidate every line (taken only when idle)
//     cpu_rdata, cpu_stall  - load data (valid when not stalled), core freeze
//     mem_rd_req/mem_wr_req - single-word memory read / write request
//     mem_addr, mem_wdata   - memory word address and write data
//     mem_rdata, mem_ready  - memory read data, request-completes strobe
//     hit_cnt, miss_cnt     - saturating read hit / miss counters
module riscv_dcache_ctrl
  import riscv_cache_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int LINES          = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int CNT_W          = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_flush,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int OFF_W  = word_off_w(WORDS_PER_LINE);
  localparam int IDX_W  = index_w(LINES);
  localparam int TAG_W  = tag_w(ADDR_W, LINES, WORDS_PER_LINE);
  localparam int NWORDS = LINES * WORDS_PER_LINE;

  // Address fields of the current access; the core holds them while stalled.
  logic [TAG_W-1:0] a_tag;
  logic [IDX_W-1:0] a_idx;
  logic [OFF_W-1:0] a_word;

  assign a_word = cpu_addr[BYTE_OFF_W +: OFF_W];
  assign a_idx  = cpu_addr[BYTE_OFF_W + OFF_W +: IDX_W];
  assign a_tag  = cpu_addr[ADDR_W-1 -: TAG_W];

  state_e           state_q, state_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;
  logic             replay_q, replay_d;
  logic [LINES-1:0] valid_q, valid_d;

  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [NWORDS];

  logic                   hit;
  logic [DATA_W-1:0]      hit_word;
  logic                   data_we;
  logic [IDX_W+OFF_W-1:0] data_waddr;
  logic [DATA_W-1:0]      data_wdata;
  logic                   tag_we;
  logic                   hit_inc;
  logic                   miss_inc;

  assign hit      = valid_q[a_idx] && (tag_q[a_idx] == a_tag);
  assign hit_word = data_q[{a_idx, a_word}];

  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    replay_d   = 1'b0;
    valid_d    = valid_q;
    data_we    = 1'b0;
    data_waddr = {a_idx, a_word};
    data_wdata = cpu_wdata;
    tag_we     = 1'b0;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    cpu_stall  = 1'b0;
    cpu_rdata  = '0;
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    case (state_q)
      ST_IDLE: begin
        if (cpu_flush) begin
          // A coincident access is held off one cycle and re-evaluated afterwards.
          valid_d   = '0;
          cpu_stall = cpu_rd | cpu_wr;
        end else if (cpu_wr) begin
          cpu_stall = 1'b1;
          state_d   = ST_WRITE;
        end else if (cpu_rd) begin
          if (hit) begin
            cpu_rdata = hit_word;
            // The cycle right after a refill replays the missed load; it is not a new hit.
            hit_inc   = !replay_q;
          end else begin
            cpu_stall = 1'b1;
            miss_inc  = 1'b1;
            cnt_d     = '0;
            state_d   = ST_REFILL;
          end
        end
      end

      ST_REFILL: begin
        cpu_stall  = 1'b1;
        mem_rd_req = 1'b1;
        mem_addr   = {a_tag, a_idx, cnt_q, {BYTE_OFF_W{1'b0}}};
        if (mem_ready) begin
          data_we    = 1'b1;
          data_waddr = {a_idx, cnt_q};
          data_wdata = mem_rdata;
          cnt_d      = cnt_q + OFF_W'(1);
          if (cnt_q == OFF_W'(WORDS_PER_LINE - 1)) begin
            tag_we         = 1'b1;
            valid_d[a_idx] = 1'b1;
            replay_d       = 1'b1;
            state_d        = ST_IDLE;
          end
        end
      end

      ST_WRITE: begin
        mem_wr_req = 1'b1;
        mem_addr   = cpu_addr;
        mem_wdata  = cpu_wdata;
        cpu_stall  = !mem_ready;
        if (mem_ready) begin
          // Write-through, no allocate: only a resident line is updated.
          data_we = hit;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Outputs and side effects are silenced for the whole time reset is held.
    if (!RST) begin
      cpu_stall  = 1'b0;
      cpu_rdata  = '0;
      mem_rd_req = 1'b0;
      mem_wr_req = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      data_we    = 1'b0;
      tag_we     = 1'b0;
      hit_inc    = 1'b0;
      miss_inc   = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      replay_q <= 1'b0;
      valid_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      replay_q <= replay_d;
      valid_q  <= valid_d;
    end
  end

  // NOTE: tag and data arrays are deliberately not reset; the valid bits alone qualify their contents.
  always_ff @(posedge CLK) begin
    if (data_we) data_q[data_waddr] <= data_wdata;
    if (tag_we)  tag_q[a_idx]       <= a_tag;
  end

  cache_sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk     (CLK),
    .rst_n   (RST),
    .inc_i   (hit_inc),
    .count_o (hit_cnt)
  );

  cache_sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk     (CLK),
    .rst_n   (RST),
    .inc_i   (miss_inc),
    .count_o (miss_cnt)
  );

endmodule

// File: tb/tb_riscv_dcache_ctrl.sv
// tb_riscv_dcache_ctrl
//   Directed bench for riscv_dcache_ctrl (LINES=32, WORDS_PER_LINE=4, CNT_W=4).
//   The memory model answers every request with mem_ready on its second cycle.
//   Unwritten memory words read back as {addr[15:0]^16'h5A5A, addr[15:0]}.
module tb_riscv_dcache_ctrl;

  localparam int CNT_W = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        cpu_rd, cpu_wr, cpu_flush;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_rd_req, mem_wr_req;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  riscv_dcache_ctrl #(
    .ADDR_W(32), .DATA_W(32), .LINES(32), .WORDS_PER_LINE(4), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RST(RST),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_flush(cpu_flush), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 CLK = ~CLK;

  // ---------------- memory model ----------------
  logic [31:0] wmem [int];
  logic [31:0] rd_log [$];
  logic [31:0] wr_addr_log [$];
  logic [31:0] wr_data_log [$];
  logic        wait_q;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (wmem.exists(int'(a))) return wmem[int'(a)];
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  assign mem_ready = (mem_rd_req | mem_wr_req) && wait_q;
  assign mem_rdata = mem_word(mem_addr);

  always @(posedge CLK or negedge RST) begin
    if (!RST) wait_q <= 1'b0;
    else      wait_q <= (mem_rd_req | mem_wr_req) && !mem_ready;
  end

  always @(posedge CLK) begin
    if (RST && mem_ready && mem_rd_req) rd_log.push_back(mem_addr);
    if (RST && mem_ready && mem_wr_req) begin
      wr_addr_log.push_back(mem_addr);
      wr_data_log.push_back(mem_wdata);
      wmem[int'(mem_addr)] = mem_wdata;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with the request already driven; returns at posedge+1
  // after the access completed, with the request dropped.
  task automatic wait_access(output int stalls, output logic [31:0] rdata);
    bit done;
    stalls = 0;
    rdata  = '0;
    done   = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge CLK);
      if (!cpu_stall) begin
        rdata = cpu_rdata;
        done  = 1'b1;
      end else begin
        stalls++;
      end
    end
    if (!done) begin
      checks++;
      fails++;
      $error("FAIL access_timeout: observed %0d stall cycles expected completion", stalls);
    end
    @(posedge CLK);
    #1;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, output int stalls, output logic [31:0] data);
    cpu_rd   = 1'b1;
    cpu_addr = addr;
    wait_access(stalls, data);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, output int stalls);
    logic [31:0] dummy;
    cpu_wr    = 1'b1;
    cpu_addr  = addr;
    cpu_wdata = data;
    wait_access(stalls, dummy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int          st;
    logic [31:0] d;

    RST = 1'b0; cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_flush = 1'b0;
    cpu_addr = 32'h100; cpu_wdata = '0;
    repeat (2) @(negedge CLK);
    check("rst_stall",    32'(cpu_stall),  32'd0);
    check("rst_rd_req",   32'(mem_rd_req), 32'd0);
    check("rst_wr_req",   32'(mem_wr_req), 32'd0);
    check("rst_mem_addr", mem_addr,        32'h0);
    check("rst_rdata",    cpu_rdata,       32'h0);
    check("rst_hit_cnt",  32'(hit_cnt),    32'd0);
    check("rst_miss_cnt", 32'(miss_cnt),   32'd0);
    cpu_rd = 1'b0;
    RST = 1'b1;
    @(posedge CLK); #1;

    // Cold miss on 0x100: 1 idle + 4 words x 2 cycles = 9 stall cycles.
    do_read(32'h100, st, d);
    check("miss100_stall", 32'(st), 32'd9);
    check("miss100_data",  d,       32'h5B5A0100);
    check("refill_words",  32'(rd_log.size()), 32'd4);
    if (rd_log.size() == 4) begin
      check("refill_a0", rd_log[0], 32'h100);
      check("refill_a1", rd_log[1], 32'h104);
      check("refill_a2", rd_log[2], 32'h108);
      check("refill_a3", rd_log[3], 32'h10C);
    end
    check("miss100_miss", 32'(miss_cnt), 32'd1);
    check("miss100_hit",  32'(hit_cnt),  32'd0);

    do_read(32'h104, st, d);
    check("hit104_stall", 32'(st), 32'd0);
    check("hit104_data",  d,       32'h5B5E0104);
    check("hit104_hit",   32'(hit_cnt), 32'd1);

    // 0x300 shares index 16 with 0x100.
    rd_log.delete();
    do_read(32'h300, st, d);
    check("miss300_stall", 32'(st), 32'd9);
    check("miss300_data",  d,       32'h595A0300);
    check("miss300_first", (rd_log.size() > 0) ? rd_log[0] : 32'hFFFF_FFFF, 32'h300);
    check("miss300_miss",  32'(miss_cnt), 32'd2);
    do_read(32'h100, st, d);
    check("evict100_stall", 32'(st), 32'd9);
    check("evict100_miss",  32'(miss_cnt), 32'd3);
    do_read(32'h300, st, d);
    check("back300_miss", 32'(miss_cnt), 32'd4);

    // Write hit: write-through and cached copy updated.
    do_write(32'h304, 32'hDEADBEEF, st);
    check("wr304_stall", 32'(st), 32'd2);
    check("wr304_count", 32'(wr_addr_log.size()), 32'd1);
    if (wr_addr_log.size() == 1) begin
      check("wr304_addr", wr_addr_log[0], 32'h304);
      check("wr304_data", wr_data_log[0], 32'hDEADBEEF);
    end
    do_read(32'h304, st, d);
    check("rd304_stall", 32'(st), 32'd0);
    check("rd304_data",  d,       32'hDEADBEEF);
    check("rd304_hit",   32'(hit_cnt), 32'd2);

    // Write miss: memory only, no allocate.
    do_write(32'h500, 32'h12345678, st);
    check("wr500_stall", 32'(st), 32'd2);
    check("wr500_mem",   mem_word(32'h500), 32'h12345678);
    do_read(32'h500, st, d);
    check("rd500_stall", 32'(st), 32'd9);
    check("rd500_data",  d,       32'h12345678);
    check("rd500_miss",  32'(miss_cnt), 32'd5);

    // Reset in the third refill cycle of a miss on 0x700.
    cpu_rd = 1'b1; cpu_addr = 32'h700;
    repeat (3) begin @(posedge CLK); #1; end
    check("pre_rst_rd_req", 32'(mem_rd_req), 32'd1);
    RST = 1'b0;
    #1;
    check("midrst_rd_req", 32'(mem_rd_req), 32'd0);
    check("midrst_stall",  32'(cpu_stall),  32'd0);
    check("midrst_hit",    32'(hit_cnt),    32'd0);
    check("midrst_miss",   32'(miss_cnt),   32'd0);
    cpu_rd = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;

    do_read(32'h300, st, d);
    check("postrst300_stall", 32'(st), 32'd9);
    check("postrst300_data",  d,       32'h595A0300);
    check("postrst300_miss",  32'(miss_cnt), 32'd1);
    do_read(32'h304, st, d);
    check("postrst304_data",  d,       32'hDEADBEEF);
    check("postrst304_hit",   32'(hit_cnt), 32'd1);

    // Flush in idle, then the line misses again.
    cpu_flush = 1'b1;
    @(posedge CLK); #1;
    cpu_flush = 1'b0;
    do_read(32'h300, st, d);
    check("flush_miss_stall", 32'(st), 32'd9);
    check("flush_miss_cnt",   32'(miss_cnt), 32'd2);

    // Flush together with a read: stalled one cycle, then the read misses.
    cpu_flush = 1'b1; cpu_rd = 1'b1; cpu_addr = 32'h300;
    @(negedge CLK);
    check("flush_coincide_stall", 32'(cpu_stall), 32'd1);
    @(posedge CLK); #1;
    cpu_flush = 1'b0;
    wait_access(st, d);
    check("flush_reeval_stall", 32'(st), 32'd9);
    check("flush_reeval_data",  d,       32'h595A0300);
    check("flush_reeval_miss",  32'(miss_cnt), 32'd3);
    check("flush_reeval_hit",   32'(hit_cnt),  32'd1);

    // 20 more hits: 1 + 20 saturates a 4-bit counter at 15.
    for (int i = 0; i < 20; i++) do_read(32'h300, st, d);
    check("sat_last_stall", 32'(st), 32'd0);
    check("sat_hit_cnt",    32'(hit_cnt),  32'd15);
    check("sat_miss_cnt",   32'(miss_cnt), 32'd3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
